poly_loader: RTL and testbench
==============================

# poly_loader

Upstream feeder for `ntt_processor`. Accepts a natural-order stream of 256 12-bit coefficients over a valid/ready handshake and optionally reduces each one mod q = 3329. It pairs adjacent coefficients and writes them into the 96-bit polynomial RAM in the interleaved word/lane layout the NTT core reads, using per-lane write masks. One polynomial is loaded per `start`.

## Interface
- `Q`, 3329: Kyber modulus used for reduction.
- `N`, 256: coefficients per polynomial, fixed; 128 writes per load.
- `clk  in  1`: sole clock; all logic on rising edge.
- `rst  in  1`: synchronous, active-high reset.
- `start  in  1`: one-cycle request to begin a load; ignored unless IDLE.
- `w_start_offset  in  8`: RAM base word address; sampled on accepted `start`.
- `in_valid  in  1`: `in_coeff` is valid.
- `in_ready  out  1`: block accepts `in_coeff` this cycle.
- `in_coeff  in  12`: coefficient; index implied by arrival order, 0..255.
- `ram_busy  in  1`: RAM port not available; a pending write stalls.
- `w_data_en  out  1`: write request.
- `w_data_addr  out  8`: write word address.
- `w_data  out  96`: lane k is bits [12k+11:12k]; unmasked lanes are driven 0.
- `w_data_mask  out  8`: per-lane write enable.
- `busy  out  1`: high in LOAD or FLUSH.
- `done  out  1`: one-cycle pulse when the last write commits.

## Operation
- **FSM states:** IDLE, LOAD, FLUSH.
  - IDLE -> LOAD on `start`. This latches the offset and clears the coefficient counter `idx` (8 bits).
  - LOAD -> FLUSH when coefficient 255 is accepted.
  - FLUSH -> IDLE when the 128th write commits; `done` pulses in that cycle.
- **Accept:** a coefficient is accepted when `in_valid && in_ready`. Each acceptance increments `idx`.
- **Even coefficient (`idx[0]==0`):** stored in the pair register.
- **Odd coefficient:** combined with the pair register and loaded into the write register, which raises `w_data_en`.
- **Mapping for coefficient i:**
  - word address w = bitrev5(i[5:1]);
  - lane = {i[6], i[7], i[0]};
  - `w_data_addr` = `w_start_offset` + w, mod 256 (wraps).
  - Each write sets exactly 2 adjacent mask bits: 0x03, 0x0C, 0x30 or 0xC0.
- **Commit:** a write commits on a cycle with `w_data_en && !ram_busy`. While it is uncommitted, `w_data`, `w_data_addr` and `w_data_mask` hold stable.
- **`in_ready` rules:**
  - Low in IDLE and FLUSH.
  - In LOAD, low only when the incoming coefficient is odd and the write register holds an uncommitted write that does not commit this cycle.
  - An even coefficient is always acceptable in LOAD.
- **Reset mid-operation:** returns to IDLE and discards pair and write registers; no partial write is issued.
- **`start` in LOAD/FLUSH:** ignored; no restart.

## Timing
- **Reset values:** `in_ready`=0, `w_data_en`=0, `w_data_addr`=0, `w_data`=0, `w_data_mask`=0, `busy`=0, `done`=0.
- **Start:** `start` at edge t puts the block in LOAD at t+1, with `in_ready` high from t+1.
- **Write latency:** an odd coefficient accepted at edge t gives `w_data_en` high in cycle t+1 (registered). With `ram_busy` low, the write commits at t+1.
- **Throughput:** 1 coefficient/cycle sustained with `ram_busy` low. A full load takes 256 accept cycles plus 1 cycle for the final write; `done` pulses in the cycle of the final commit.
- **Simultaneous events:** a commit and a new odd accept in the same cycle are legal. The write register reloads with no bubble.

## Configuration
- **`POLY_LOADER_MODRED_EN` defined:**
  - `in_coeff` ≥ 3329 is replaced by `in_coeff` − 3329, via one conditional subtract before the pair register; values < 3329 pass unchanged.
  - Latency is unchanged.
- **Undefined:** `in_coeff` passes through unmodified. Inputs are required to be < 3329.

## Test plan
- **Natural stream:** offset 0, `in_coeff` = i for i = 0..255, `ram_busy`=0. Required writes:
  - (0,1) -> addr 0, mask 0x03, lanes 0/1 = 0/1;
  - (2,3) -> addr 16, mask 0x03;
  - (64,65) -> addr 0, mask 0x30;
  - (128,129) -> addr 0, mask 0x0C;
  - (192,193) -> addr 0, mask 0xC0.
  - The merged RAM image equals the NTT input ordering (word 1 = {225,224,97,96,161,160,33,32}). `done` pulses once, 128 writes total.
- **Address wrap:** offset 250 -> pair (2,3) writes addr (250+16) mod 256 = 10.
- **Backpressure:** hold `ram_busy`=1 for 5 cycles after the first write. `w_data_*` stay stable, the next even coefficient is accepted, `in_ready` drops for the odd one, and no write is lost or duplicated.
- **Reduction:** with `POLY_LOADER_MODRED_EN`, `in_coeff` = 4095 gives lane value 766 and 3329 gives 0. Without the macro, 3328 passes as 3328.
- **Reset mid-load:** `rst` after 37 coefficients -> all outputs at reset values next cycle. A subsequent full load produces exactly 128 correct writes.
- **Spurious start:** `start` pulsed during LOAD -> ignored; `idx` continues and `done` pulses once.

Source files
------------

// File: rtl/poly_loader.sv
// Coefficient stream loader for the NTT polynomial RAM: pairs coefficients into masked 96-bit lane writes.
// Optional mod-q input reduction is enabled by defining POLY_LOADER_MODRED_EN.

module poly_loader_lane #(
  parameter int CW       = 12,
  parameter int LANE_ODD = 0
) (
  input  logic          sel,
  input  logic [CW-1:0] even_c,
  input  logic [CW-1:0] odd_c,
  output logic [CW-1:0] lane_d,
  output logic          lane_en
);
  assign lane_en = sel;
  assign lane_d  = sel ? ((LANE_ODD != 0) ? odd_c : even_c) : '0;
endmodule

module poly_loader #(
  parameter int Q         = 3329,
  parameter int N         = 256,
  parameter int CW        = 12,
  parameter int NUM_LANES = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [7:0]              w_start_offset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [CW-1:0]           in_coeff,
  input  logic                    ram_busy,
  output logic                    w_data_en,
  output logic [7:0]              w_data_addr,
  output logic [NUM_LANES*CW-1:0] w_data,
  output logic [NUM_LANES-1:0]    w_data_mask,
  output logic                    busy,
  output logic                    done
);
  typedef enum logic [1:0] {IDLE, LOAD, FLUSH} state_t;

  typedef struct packed {
    logic                          en;
    logic [7:0]                    addr;
    logic [NUM_LANES-1:0][CW-1:0]  data;
    logic [NUM_LANES-1:0]          mask;
  } wr_t;

  state_t  state;
  wr_t     wr_q;
  logic [7:0]    idx, base;
  logic [CW-1:0] pair_q, coeff_v;
  logic          accept, commit;
  logic [4:0]    wsel;
  logic [1:0]    pg;
  logic [NUM_LANES-1:0][CW-1:0] lanes_d;
  logic [NUM_LANES-1:0]         mask_d;

  function automatic logic [CW-1:0] modred(input logic [CW-1:0] c);
    return (c >= CW'(Q)) ? c - CW'(Q) : c;
  endfunction

`ifdef POLY_LOADER_MODRED_EN
  assign coeff_v = modred(in_coeff);
`else
  assign coeff_v = in_coeff;
`endif

  // A pending write only blocks the odd half of a pair; even coefficients go to pair_q.
  assign commit   = wr_q.en && !ram_busy;
  assign in_ready = (state == LOAD) && !(idx[0] && wr_q.en && ram_busy);
  assign accept   = in_valid && in_ready;
  assign busy     = (state != IDLE);
  assign done     = (state == FLUSH) && commit;

  assign w_data_en   = wr_q.en;
  assign w_data_addr = wr_q.addr;
  assign w_data      = wr_q.data;
  assign w_data_mask = wr_q.mask;

  // Word index is the bit-reversed pair number within a 64-block; bits 7:6 pick the lane pair.
  assign wsel = {idx[1], idx[2], idx[3], idx[4], idx[5]};
  assign pg   = {idx[6], idx[7]};

  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    poly_loader_lane #(.CW(CW), .LANE_ODD(k % 2)) u_lane (
      .sel    (pg == 2'(k / 2)),
      .even_c (pair_q),
      .odd_c  (coeff_v),
      .lane_d (lanes_d[k]),
      .lane_en(mask_d[k])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      idx    <= '0;
      base   <= '0;
      pair_q <= '0;
      wr_q   <= '0;
    end else begin
      case (state)
        IDLE:  if (start) begin
                 state <= LOAD;
                 base  <= w_start_offset;
                 idx   <= '0;
               end
        LOAD:  if (accept) begin
                 idx <= idx + 8'd1;
                 if (idx == 8'(N - 1)) state <= FLUSH;
               end
        FLUSH: if (commit) state <= IDLE;
        default: state <= IDLE;
      endcase

      if (accept && !idx[0]) pair_q <= coeff_v;

      if (accept && idx[0]) begin
        wr_q.en   <= 1'b1;
        wr_q.addr <= base + {3'b000, wsel};
        wr_q.data <= lanes_d;
        wr_q.mask <= mask_d;
      end else if (commit) begin
        wr_q.en <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_poly_loader.sv
// Directed bench for poly_loader with a write scoreboard and a merged RAM image.
module tb_poly_loader;
  logic        clk = 1'b0;
  logic        rst, start, in_valid, in_ready, ram_busy, w_data_en, busy, done;
  logic [7:0]  w_start_offset, w_data_addr, w_data_mask;
  logic [11:0] in_coeff;
  logic [95:0] w_data;

  always #5 clk = ~clk;

  poly_loader dut (
    .clk(clk), .rst(rst), .start(start), .w_start_offset(w_start_offset),
    .in_valid(in_valid), .in_ready(in_ready), .in_coeff(in_coeff),
    .ram_busy(ram_busy), .w_data_en(w_data_en), .w_data_addr(w_data_addr),
    .w_data(w_data), .w_data_mask(w_data_mask), .busy(busy), .done(done)
  );

  typedef struct packed {
    logic [7:0]  addr;
    logic [7:0]  mask;
    logic [95:0] data;
  } exp_t;

  exp_t        q[$];
  int          n_chk = 0, n_fail = 0;
  int          wr_cnt, done_cnt, bp, tb_idx;
  logic        ld, prev_pend;
  logic [7:0]  off_m, p_addr, p_mask;
  logic [11:0] pair_m;
  logic [95:0] p_data;
  logic [7:0]  got_addr[128];
  logic [7:0]  got_mask[128];
  logic [95:0] img[256];

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] expv);
    n_chk++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [11:0] red(input logic [11:0] c);
`ifdef POLY_LOADER_MODRED_EN
    return (c >= 12'd3329) ? c - 12'd3329 : c;
`else
    return c;
`endif
  endfunction

  function automatic int brev5(input int x);
    int r = 0;
    for (int b = 0; b < 5; b++) if ((x >> b) & 1) r |= 1 << (4 - b);
    return r;
  endfunction

  task automatic model_accept(input logic [11:0] c);
    exp_t e;
    int   pgi;
    logic [11:0] v;
    v = red(c);
    if (tb_idx % 2 == 0) pair_m = v;
    else begin
      pgi    = ((tb_idx >> 6) & 1) * 2 + ((tb_idx >> 7) & 1);
      e.addr = off_m + 8'(brev5((tb_idx >> 1) & 31));
      e.mask = 8'(3 << (2 * pgi));
      e.data = 96'({v, pair_m}) << (24 * pgi);
      q.push_back(e);
    end
    tb_idx++;
    if (tb_idx == 256) ld = 1'b0;
  endtask

  task automatic step(input logic v, input logic [11:0] c, output logic acc);
    exp_t e;
    in_valid = v; in_coeff = c; ram_busy = (bp > 0);
    #1;
    if (prev_pend) begin
      chk("hold_addr", w_data_addr, p_addr);
      chk("hold_mask", w_data_mask, p_mask);
      chk("hold_data", w_data, p_data);
    end
    chk("in_ready", in_ready, ld && !((tb_idx % 2 == 1) && w_data_en && ram_busy));
    if (w_data_en && !ram_busy) begin
      n_chk++;
      assert (q.size() > 0) else begin
        n_fail++;
        $error("FAIL unexpected_write: observed addr %0h expected no write", w_data_addr);
      end
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("wr_addr", w_data_addr, e.addr);
        chk("wr_mask", w_data_mask, e.mask);
        chk("wr_data", w_data, e.data);
      end
      if (wr_cnt < 128) begin
        got_addr[wr_cnt] = w_data_addr;
        got_mask[wr_cnt] = w_data_mask;
      end
      for (int k = 0; k < 8; k++)
        if (w_data_mask[k]) img[w_data_addr][12*k +: 12] = w_data[12*k +: 12];
      wr_cnt++;
      chk("done_at_commit", done, wr_cnt == 128);
    end
    if (done) done_cnt++;
    acc = v && in_ready && !rst;
    if (acc) model_accept(c);
    prev_pend = w_data_en && ram_busy;
    p_addr = w_data_addr; p_mask = w_data_mask; p_data = w_data;
    if (bp > 0) bp--;
    @(posedge clk); #1;
  endtask

  task automatic do_load(input logic [7:0] off, input int mode, input bit bpress,
                         input bit spur, input int stop_at);
    logic acc;
    logic [11:0] c;
    int guard;
    wr_cnt = 0; done_cnt = 0; tb_idx = 0; q.delete();
    foreach (img[k]) img[k] = '0;
    w_start_offset = off; off_m = off; start = 1'b1;
    step(1'b0, 12'd0, acc);
    start = 1'b0; w_start_offset = 8'hAA; ld = 1'b1;
    chk("busy_after_start", busy, 1'b1);
    for (int i = 0; i < stop_at; i++) begin
      if (mode == 0) c = 12'(i);
`ifdef POLY_LOADER_MODRED_EN
      else if (i == 5) c = 12'd4095;
      else if (i == 6) c = 12'd3329;
      else c = 12'($urandom_range(0, 4095));
`else
      else if (i == 5) c = 12'd3328;
      else c = 12'($urandom_range(0, 3328));
`endif
      if (spur && i == 100) start = 1'b1;
      guard = 0;
      do begin
        step(1'b1, c, acc);
        start = 1'b0;
        guard++;
      end while (!acc && guard < 50);
      if (!acc) chk("accept_timeout", acc, 1'b1);
      if (bpress && i == 1) bp = 5;
    end
  endtask

  task automatic finish_load();
    logic acc;
    int guard = 0;
    while (done_cnt == 0 && guard < 20) begin
      step(1'b0, 12'd0, acc);
      guard++;
    end
    step(1'b0, 12'd0, acc);
    chk("done_count", done_cnt, 1);
    chk("write_count", wr_cnt, 128);
    chk("queue_empty", q.size(), 0);
    chk("busy_idle", busy, 1'b0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_in_ready"}, in_ready, 1'b0);
    chk({tag, "_w_en"}, w_data_en, 1'b0);
    chk({tag, "_w_addr"}, w_data_addr, 8'd0);
    chk({tag, "_w_data"}, w_data, 96'd0);
    chk({tag, "_w_mask"}, w_data_mask, 8'd0);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_done"}, done, 1'b0);
  endtask

  initial begin
    logic acc;
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_coeff = '0; ram_busy = 1'b0;
    w_start_offset = '0; bp = 0; ld = 1'b0; prev_pend = 1'b0; tb_idx = 0;
    wr_cnt = 0; done_cnt = 0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_vals("reset");
    rst = 1'b0;

    // natural stream at offset 0
    do_load(8'd0, 0, 1'b0, 1'b0, 256);
    finish_load();
    chk("p0_addr", got_addr[0], 8'd0);
    chk("p0_mask", got_mask[0], 8'h03);
    chk("p1_addr", got_addr[1], 8'd16);
    chk("p1_mask", got_mask[1], 8'h03);
    chk("p32_addr", got_addr[32], 8'd0);
    chk("p32_mask", got_mask[32], 8'h30);
    chk("p64_mask", got_mask[64], 8'h0C);
    chk("p96_mask", got_mask[96], 8'hC0);
    chk("img_w0_lo", img[0][23:0], {12'd1, 12'd0});
    chk("img_w1", img[1], {12'd225, 12'd224, 12'd97, 12'd96, 12'd161, 12'd160, 12'd33, 12'd32});

    // address wrap
    do_load(8'd250, 0, 1'b0, 1'b0, 256);
    finish_load();
    chk("wrap_p1_addr", got_addr[1], 8'd10);

    // backpressure after the first write
    do_load(8'd0, 0, 1'b1, 1'b0, 256);
    finish_load();
    chk("bp_img_w1", img[1], {12'd225, 12'd224, 12'd97, 12'd96, 12'd161, 12'd160, 12'd33, 12'd32});

    // random values with a spurious start mid-load
    do_load(8'd7, 1, 1'b0, 1'b1, 256);
    finish_load();
`ifdef POLY_LOADER_MODRED_EN
    chk("red_4095", img[15][23:12], 12'd766);
    chk("red_3329", img[31][11:0], 12'd0);
`else
    chk("pass_3328", img[15][23:12], 12'd3328);
`endif

    // reset after 37 coefficients, then a clean full load
    do_load(8'd0, 0, 1'b0, 1'b0, 37);
    rst = 1'b1;
    step(1'b0, 12'd0, acc);
    rst = 1'b0; ld = 1'b0; q.delete(); prev_pend = 1'b0;
    chk_reset_vals("midrst");
    do_load(8'd3, 0, 1'b0, 1'b0, 256);
    finish_load();
    chk("post_rst_img_w4", img[4], {12'd225, 12'd224, 12'd97, 12'd96, 12'd161, 12'd160, 12'd33, 12'd32});

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
